// File: rtl/rr_arbiter4.sv
// Four-source round-robin arbiter that steers an external 4:1 mux and registers
// the winning item into a single-entry, full-throughput output stage.
module rr_arbiter4 #(
  parameter int DWidth = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [3:0]        req_valid_i,
  output logic [3:0]        req_grant_o,
  output logic [1:0]        select_o,
  input  logic [DWidth-1:0] mux_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DWidth-1:0] out_data_o,
  output logic [1:0]        out_src_o
);

  logic [1:0]        ptr_q, ptr_d;
  logic              out_valid_q, out_valid_d;
  logic [DWidth-1:0] out_data_q, out_data_d;
  logic [1:0]        out_src_q, out_src_d;

  logic [1:0] winner;
  logic [1:0] idx;
  logic       found;
  logic       any_req;
  logic       accept;
  logic       grant_en;

  // Scan from the pointer upward; 2-bit index arithmetic wraps naturally.
  always_comb begin
    winner = ptr_q;
    found  = 1'b0;
    idx    = 2'd0;
    for (int i = 0; i < 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!found && req_valid_i[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign any_req  = |req_valid_i;
  assign accept   = !out_valid_q || out_ready_i;
  // Gating with rst_ni keeps grants quiet while reset is held.
  assign grant_en = accept && any_req && rst_ni;

  assign select_o    = any_req ? winner : 2'd0;
  assign req_grant_o = grant_en ? (4'b0001 << winner) : 4'b0000;

  always_comb begin
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    if (grant_en) begin
      out_valid_d = 1'b1;
      out_data_d  = mux_data_i;
      out_src_d   = winner;
      ptr_d       = winner + 2'd1;
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q       <= 2'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= 2'd0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_src_o   = out_src_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4: per-cycle vector table plus hand-written
// sequences for round-robin from reset and asynchronous reset during a stall.
module tb_rr_arbiter4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [3:0]  grant;
  logic [1:0]  sel;
  logic [31:0] mdata;
  logic        ovalid;
  logic        oready;
  logic [31:0] odata;
  logic [1:0]  osrc;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  rr_arbiter4 #(.DWidth(32)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .req_valid_i(req),
    .req_grant_o(grant),
    .select_o   (sel),
    .mux_data_i (mdata),
    .out_valid_o(ovalid),
    .out_ready_i(oready),
    .out_data_o (odata),
    .out_src_o  (osrc)
  );

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    logic        ready;
    logic [3:0]  g;
    logic [1:0]  s;
    logic        v;
    logic [31:0] od;
    logic [1:0]  os;
  } vec_t;

  vec_t vt[15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n  = 1'b0;
    req    = 4'b0000;
    oready = 1'b0;
    mdata  = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int exp_seq[6];
    exp_seq = '{0, 1, 2, 3, 0, 1};

    // Rows apply in one cycle each, starting from ptr=0 and an empty output.
    vt[0]  = '{4'b0100, 32'hDEADBEEF, 1'b1, 4'b0100, 2'd2, 1'b0, 32'h0,        2'd0};
    vt[1]  = '{4'b0000, 32'h0,        1'b1, 4'b0000, 2'd0, 1'b1, 32'hDEADBEEF, 2'd2};
    vt[2]  = '{4'b0010, 32'h11111111, 1'b1, 4'b0010, 2'd1, 1'b0, 32'hDEADBEEF, 2'd2};
    vt[3]  = '{4'b1001, 32'h22222222, 1'b1, 4'b1000, 2'd3, 1'b1, 32'h11111111, 2'd1};
    vt[4]  = '{4'b1111, 32'hA0,       1'b1, 4'b0001, 2'd0, 1'b1, 32'h22222222, 2'd3};
    vt[5]  = '{4'b1111, 32'hA1,       1'b1, 4'b0010, 2'd1, 1'b1, 32'hA0,       2'd0};
    vt[6]  = '{4'b1111, 32'hA2,       1'b1, 4'b0100, 2'd2, 1'b1, 32'hA1,       2'd1};
    vt[7]  = '{4'b1111, 32'hA3,       1'b1, 4'b1000, 2'd3, 1'b1, 32'hA2,       2'd2};
    vt[8]  = '{4'b1111, 32'hA4,       1'b1, 4'b0001, 2'd0, 1'b1, 32'hA3,       2'd3};
    vt[9]  = '{4'b0011, 32'hB0,       1'b0, 4'b0000, 2'd1, 1'b1, 32'hA4,       2'd0};
    vt[10] = '{4'b0011, 32'hB0,       1'b0, 4'b0000, 2'd1, 1'b1, 32'hA4,       2'd0};
    vt[11] = '{4'b0011, 32'hB0,       1'b0, 4'b0000, 2'd1, 1'b1, 32'hA4,       2'd0};
    vt[12] = '{4'b0011, 32'hB1,       1'b1, 4'b0010, 2'd1, 1'b1, 32'hA4,       2'd0};
    vt[13] = '{4'b0000, 32'h0,        1'b1, 4'b0000, 2'd0, 1'b1, 32'hB1,       2'd1};
    vt[14] = '{4'b0000, 32'h0,        1'b0, 4'b0000, 2'd0, 1'b0, 32'hB1,       2'd1};

    // Reset state, with select following the ptr=0 priority order.
    rst_n  = 1'b0;
    req    = 4'b0110;
    oready = 1'b1;
    mdata  = 32'h12345678;
    @(negedge clk);
    #1;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_sel",   32'(sel),   32'd1);
    chk("rst_valid", 32'(ovalid), 32'h0);
    chk("rst_data",  odata,      32'h0);
    chk("rst_src",   32'(osrc),  32'h0);

    // Round-robin from reset with all sources requesting.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      req    = 4'b1111;
      oready = 1'b1;
      mdata  = 32'(k);
      #1;
      chk($sformatf("rr_grant[%0d]", k), 32'(grant), 32'(4'b0001 << exp_seq[k]));
      if (k >= 1) begin
        chk($sformatf("rr_valid[%0d]", k), 32'(ovalid), 32'h1);
        chk($sformatf("rr_src[%0d]", k),   32'(osrc),   32'(exp_seq[k-1]));
        chk($sformatf("rr_data[%0d]", k),  odata,       32'(k - 1));
      end
    end

    // Table-driven vectors.
    do_reset();
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      req    = vt[i].req;
      mdata  = vt[i].data;
      oready = vt[i].ready;
      #1;
      chk($sformatf("v%0d_grant", i), 32'(grant),  32'(vt[i].g));
      chk($sformatf("v%0d_sel", i),   32'(sel),    32'(vt[i].s));
      chk($sformatf("v%0d_valid", i), 32'(ovalid), 32'(vt[i].v));
      chk($sformatf("v%0d_data", i),  odata,       vt[i].od);
      chk($sformatf("v%0d_src", i),   32'(osrc),   32'(vt[i].os));
    end

    // Asynchronous reset while an item is stalled.
    @(negedge clk);
    req    = 4'b0100;
    mdata  = 32'hC0C0C0C0;
    oready = 1'b0;
    @(negedge clk);
    req = 4'b0000;
    #1;
    chk("stall_valid", 32'(ovalid), 32'h1);
    chk("stall_src",   32'(osrc),   32'd2);
    chk("stall_data",  odata,       32'hC0C0C0C0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(ovalid), 32'h0);
    chk("arst_data",  odata,       32'h0);
    chk("arst_src",   32'(osrc),   32'h0);
    chk("arst_grant", 32'(grant),  32'h0);
    @(negedge clk);
    #2;
    rst_n  = 1'b1;
    req    = 4'b1010;
    mdata  = 32'hD1D1D1D1;
    oready = 1'b1;
    #1;
    chk("post_rst_grant", 32'(grant), 32'h2);
    chk("post_rst_sel",   32'(sel),   32'd1);
    @(posedge clk);
    #1;
    chk("post_rst_valid", 32'(ovalid), 32'h1);
    chk("post_rst_src",   32'(osrc),   32'd1);
    chk("post_rst_data",  odata,       32'hD1D1D1D1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
